// File: rtl/wb_mailbox_pkg.sv
// Shared constants for the Wishbone mailbox: register offsets, STATUS and
// IRQEN bit positions, and the bus acknowledge FSM state type.
package wb_mailbox_pkg;

  // Register offsets selected by adr_i[1:0]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_IRQEN  = 2'd2;
  localparam logic [1:0] REG_ID     = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_NONEMPTY  = 0;
  localparam int ST_TX_FULL      = 1;
  localparam int ST_OVF          = 2;
  localparam int ST_UDF          = 3;
  localparam int ST_TX_EMPTY     = 4;
  localparam int ST_RX_COUNT_LSB = 8;
  localparam int ST_TX_FREE_LSB  = 16;

  // IRQEN bit positions
  localparam int IE_RX_NONEMPTY = 0;
  localparam int IE_TX_EMPTY    = 1;

  // Acknowledge FSM: IDLE accepts an access, ACK drives ack_o for one cycle
  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_ACK  = 1'b1
  } ack_state_t;

endpackage

// File: rtl/wb_mailbox_sfifo.sv
// Synchronous first-word-fall-through FIFO. A push is ignored while full and
// a pop is ignored while empty; a simultaneous push and pop keeps the count.
module wb_mailbox_sfifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone target exposing a TX FIFO (bus -> stream), an RX FIFO
// (stream -> bus), a STATUS register with sticky ovf/udf flags, an IRQEN
// register, an ID register, and a one-cycle interrupt strobe.
//
// Handshake rules: on the bus, a decoded stb_i seen while idle is executed on
// the next edge and acknowledged for exactly one cycle, followed by one cycle
// with ack_o low; on the streams, a word moves on any edge where valid and
// ready are both high, and ready never depends on valid.
module wb_mailbox
  import wb_mailbox_pkg::*;
#(
  parameter logic [14:0] BASE       = 15'h0000,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [31:0] ID         = 32'h4D42_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        irq
);

  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  ack_state_t state_q, state_d;
  logic        access;
  logic        decoded;
  logic        wr, rd;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;
  logic [31:0] status_word;
  logic        ovf_q, udf_q;
  logic [1:0]  irqen_q;
  logic        cond, cond_q;

  logic                tx_full, tx_empty;
  logic [DEPTH_LOG2:0] tx_count, tx_free;
  logic [31:0]         rx_head;
  logic                rx_full, rx_empty;
  logic [DEPTH_LOG2:0] rx_count;

  assign decoded = (adr_i[14:2] == BASE[14:2]);
  assign reg_sel = adr_i[1:0];
  assign wr      = access & we_i;
  assign rd      = access & ~we_i;
  assign ack_o   = (state_q == ACK_ACK);

  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_free  = DEPTH_CNT - tx_count;

  wb_mailbox_sfifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr & (reg_sel == REG_DATA)),
    .push_data (dat_i),
    .pop       (tx_ready),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  wb_mailbox_sfifo #(.WIDTH(32), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rd & (reg_sel == REG_DATA)),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Acknowledge FSM state register; reset abandons any access in flight
  always_ff @(posedge clk) begin
    if (reset) state_q <= ACK_IDLE;
    else       state_q <= state_d;
  end

  // Next state and access strobe: only an idle cycle may start an access
  always_comb begin
    state_d = state_q;
    access  = 1'b0;
    case (state_q)
      ACK_IDLE: begin
        if (stb_i && decoded) begin
          state_d = ACK_ACK;
          access  = 1'b1;
        end
      end
      ACK_ACK: state_d = ACK_IDLE;
      default: state_d = ACK_IDLE;
    endcase
  end

  // STATUS word assembled from the current FIFO and flag state
  always_comb begin
    status_word = '0;
    status_word[ST_RX_NONEMPTY] = ~rx_empty;
    status_word[ST_TX_FULL]     = tx_full;
    status_word[ST_OVF]         = ovf_q;
    status_word[ST_UDF]         = udf_q;
    status_word[ST_TX_EMPTY]    = tx_empty;
    status_word[ST_RX_COUNT_LSB +: 8] = 8'(rx_count);
    status_word[ST_TX_FREE_LSB  +: 8] = 8'(tx_free);
  end

  // Read data mux; an empty RX FIFO reads as zero
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_DATA:   rd_data = rx_empty ? 32'd0 : rx_head;
      REG_STATUS: rd_data = status_word;
      REG_IRQEN:  rd_data = {30'd0, irqen_q};
      REG_ID:     rd_data = ID;
      default:    rd_data = '0;
    endcase
  end

  // Registered read data, sticky flags and interrupt enables; set beats clear
  always_ff @(posedge clk) begin
    if (reset) begin
      dat_o   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      irqen_q <= '0;
    end else begin
      dat_o <= rd ? rd_data : 32'd0;
      if (wr && reg_sel == REG_DATA && tx_full)
        ovf_q <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && dat_i[ST_OVF])
        ovf_q <= 1'b0;
      if (rd && reg_sel == REG_DATA && rx_empty)
        udf_q <= 1'b1;
      else if (wr && reg_sel == REG_STATUS && dat_i[ST_UDF])
        udf_q <= 1'b0;
      if (wr && reg_sel == REG_IRQEN)
        irqen_q <= {dat_i[IE_TX_EMPTY], dat_i[IE_RX_NONEMPTY]};
    end
  end

  assign cond = (irqen_q[IE_RX_NONEMPTY] & ~rx_empty) |
                (irqen_q[IE_TX_EMPTY] & tx_empty);

  // Interrupt strobe on each rising edge of the registered condition
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      cond_q <= cond;
      irq    <= cond & ~cond_q;
    end
  end

endmodule
